// File: rtl/register_e1of4_pkg.sv
// Shared definitions for the e1of4 register sequencer: command encodings, FSM states,
// and the 16-bit Fibonacci LFSR used when REG_SEQ_LFSR_EN is defined.
package register_e1of4_pkg;

    localparam logic [1:0] CTRL_READ  = 2'b00;
    localparam logic [1:0] CTRL_WRITE = 2'b01;
    localparam logic [1:0] CTRL_RW    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_GO_HI,
        ST_GO_LO,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting right: feedback taps are bits 0, 2, 3, 5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/register_e1of4_expfifo.sv
// Expected-read FIFO: holds shadow values awaiting comparison with received data.
// A pop in the same cycle lets a push proceed even when full.
module register_e1of4_expfifo #(
    parameter int DW    = 2,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/register_e1of4_sequencer.sv
// Drives READ/WRITE/READ+WRITE tokens over a 4-phase handshake and checks returned reads
// against a shadow register. Define REG_SEQ_LFSR_EN for LFSR commands (then DW <= 16).
module register_e1of4_sequencer
    import register_e1of4_pkg::*;
#(
    parameter int            DW        = 2,
    parameter int            NO_TOKENS = 16,
    parameter int            EXP_DEPTH = 4,
    parameter logic [DW-1:0] INIT_VAL  = '0,
    parameter int            TIMEOUT   = 1024
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] cmd_data,
    output logic [1:0]    cmd_ctrl,
    output logic          cmd_go,
    input  logic          cmd_ack,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic [15:0]   tx_count,
    output logic [15:0]   rx_count,
    output logic [15:0]   err_count,
    output logic          error,
    output logic          timeout,
    output logic [2:0]    dbg_state_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_e    state_q, state_d;
    logic          ack_s1_q, ack_s2_q, rxv_s1_q, rxv_s2_q, rxv_s3_q;
    logic          ack_sync, rx_edge, run_start, load, issue, tmo_hit;
    logic [DW-1:0] gen_data, cmd_data_q, shadow_q, fifo_rdata;
    logic [1:0]    gen_ctrl, cmd_ctrl_q;
    logic          cmd_go_q, fifo_full, fifo_empty, error_q, timeout_q;
    logic [15:0]   tx_count_q, rx_count_q, err_count_q;
    logic [TW-1:0] tmr_q;

    // Synchronisers stay un-reset so a RESET never makes a high ack look low.
    always_ff @(posedge CLK) begin
        ack_s1_q <= cmd_ack;
        ack_s2_q <= ack_s1_q;
        rxv_s1_q <= rx_valid;
        rxv_s2_q <= rxv_s1_q;
        rxv_s3_q <= rxv_s2_q;
    end

    assign ack_sync  = ack_s2_q;
    assign rx_edge   = rxv_s2_q && !rxv_s3_q;
    assign run_start = start && (state_q == ST_IDLE || state_q == ST_DONE);

`ifdef REG_SEQ_LFSR_EN
    logic [15:0] lfsr_q, lfsr_nx;
    assign lfsr_nx  = lfsr_next(lfsr_q);
    assign gen_ctrl = (lfsr_q[1:0] == 2'b11) ? CTRL_READ : lfsr_q[1:0];
    assign gen_data = lfsr_nx[DW-1:0];

    always_ff @(posedge CLK) begin
        if (RESET)      lfsr_q <= LFSR_SEED;
        else if (issue) lfsr_q <= lfsr_nx;
    end
`else
    logic [2:0] idx_q;
    always_comb begin
        gen_ctrl = CTRL_READ;
        gen_data = '0;
        case (idx_q)
            3'd1:    begin gen_ctrl = CTRL_WRITE; gen_data = '1; end
            3'd3:    gen_ctrl = CTRL_WRITE;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET)      idx_q <= '0;
        else if (issue) idx_q <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        issue   = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SETUP;
            ST_SETUP: if (!ack_sync && (gen_ctrl == CTRL_WRITE || !fifo_full || rx_edge)) begin
                load    = 1'b1;
                state_d = ST_GO_HI;
            end
            ST_GO_HI: if (ack_sync) begin
                issue   = 1'b1;
                state_d = ST_GO_LO;
            end
            ST_GO_LO: if (!ack_sync)
                state_d = (tx_count_q == 16'(NO_TOKENS)) ? ST_DRAIN : ST_SETUP;
            ST_DRAIN: if (fifo_empty) begin
                state_d = ST_DONE;
            end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                tmo_hit = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE:  if (start) state_d = ST_SETUP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Command fields are registered a cycle before go rises and held until the next SETUP.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd_data_q <= '0;
            cmd_ctrl_q <= CTRL_READ;
            cmd_go_q   <= 1'b0;
            shadow_q   <= INIT_VAL;
        end else begin
            cmd_go_q <= (state_q == ST_GO_HI);
            if (load) begin
                cmd_data_q <= gen_data;
                cmd_ctrl_q <= gen_ctrl;
            end
            if (issue && cmd_ctrl_q != CTRL_READ) shadow_q <= cmd_data_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || state_q != ST_DRAIN) tmr_q <= '0;
        else                              tmr_q <= tmr_q + TW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET || run_start) begin
            tx_count_q  <= '0;
            rx_count_q  <= '0;
            err_count_q <= '0;
            error_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if (issue) tx_count_q <= sat_inc(tx_count_q);
            if (rx_edge) begin
                rx_count_q <= sat_inc(rx_count_q);
                if (fifo_empty || rx_data != fifo_rdata) begin
                    err_count_q <= sat_inc(err_count_q);
                    error_q     <= 1'b1;
                end
            end
            if (tmo_hit) begin
                timeout_q <= 1'b1;
                error_q   <= 1'b1;
            end
        end
    end

    register_e1of4_expfifo #(.DW(DW), .DEPTH(EXP_DEPTH)) u_expfifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .clr_i   (run_start),
        .push_i  (issue && cmd_ctrl_q != CTRL_WRITE),
        .pop_i   (rx_edge && !run_start),
        .wdata_i (shadow_q),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign cmd_data    = cmd_data_q;
    assign cmd_ctrl    = cmd_ctrl_q;
    assign cmd_go      = cmd_go_q;
    assign tx_count    = tx_count_q;
    assign rx_count    = rx_count_q;
    assign err_count   = err_count_q;
    assign error       = error_q;
    assign timeout     = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_register_e1of4_sequencer.sv
// Bench for register_e1of4_sequencer: emulates the transmitters, an ideal register and a
// receiver with random delays, and checks the sequencer against a behavioural model.
module tb_register_e1of4_sequencer;
    localparam int            DW    = 4;
    localparam int            NT    = 7;
    localparam int            DEPTH = 2;
    localparam int            TMO   = 64;
    localparam logic [DW-1:0] INIT  = 4'h3;
    localparam int            W     = DW + 2;

    logic          CLK = 1'b0, RESET = 1'b1, start = 1'b0, rx_valid = 1'b0;
    logic          ack_auto = 1'b0, ack_man = 1'b0, auto_tx = 1'b1, chk_en = 1'b1, rx_busy = 1'b0;
    logic [DW-1:0] rx_data = '0;
    wire           cmd_ack = auto_tx ? ack_auto : ack_man;
    wire           busy, done, cmd_go, error, timeout;
    wire  [DW-1:0] cmd_data;
    wire  [1:0]    cmd_ctrl;
    wire  [15:0]   tx_count, rx_count, err_count;
    wire  [2:0]    dbg_state;

    register_e1of4_sequencer #(.DW(DW), .NO_TOKENS(NT), .EXP_DEPTH(DEPTH), .INIT_VAL(INIT), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .busy(busy), .done(done),
        .cmd_data(cmd_data), .cmd_ctrl(cmd_ctrl), .cmd_go(cmd_go), .cmd_ack(cmd_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_count(tx_count), .rx_count(rx_count),
        .err_count(err_count), .error(error), .timeout(timeout), .dbg_state_o(dbg_state)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0, n_fail = 0;
    // Model state: command generator position, ideal register, expected commands and responses.
    int            m_idx = 0, exp_rx, exp_err, rd_no, force_corrupt, corrupt_pct, drop_read;
    int            rx_min = 3, rx_max = 8;
    logic [15:0]   m_lfsr = 16'hACE1;
    logic [DW-1:0] reg_val = INIT;
    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] resp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    task automatic model_cmds();
        logic [1:0]    c;
        logic [DW-1:0] d;
        logic [15:0]   nx;
        for (int k = 0; k < NT; k++) begin
`ifdef REG_SEQ_LFSR_EN
            nx = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            c = 2'(m_lfsr[1:0] % 3);
            d = nx[DW-1:0];
            m_lfsr = nx;
`else
            nx = '0;
            case (m_idx % 5)
                1:       begin c = 2'b01; d = '1; end
                3:       begin c = 2'b01; d = '0; end
                default: begin c = 2'b00; d = '0; end
            endcase
            m_idx++;
`endif
            exp_q.push_back({c, d});
            if (c != 2'b01) exp_rx++;
        end
    endtask

    // Transmitter plus ideal register: accepts each token, checks it against the expected command.
    initial begin : tx_emul
        logic [1:0]    c;
        logic [DW-1:0] d;
        logic [W-1:0]  e;
        bit            bad;
        forever begin
            @(negedge CLK);
            if (auto_tx && cmd_go && !RESET) begin
                c = cmd_ctrl;
                d = cmd_data;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cmd_extra: actual=token %0h/%0h expected=no token", c, d);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_ctrl", 32'(c), 32'(e[W-1:DW]));
                    if (e[W-1:DW] != 2'b00) check("cmd_data", 32'(d), 32'(e[DW-1:0]));
                end
                repeat ($urandom_range(0, 3)) @(negedge CLK);
                ack_auto = 1'b1;
                if (c != 2'b01) begin
                    rd_no++;
                    bad = (rd_no == force_corrupt) || ($urandom_range(0, 99) < corrupt_pct);
                    if (rd_no != drop_read) begin
                        resp_q.push_back(bad ? reg_val ^ DW'(1) : reg_val);
                        if (bad) exp_err++;
                    end
                end
                if (c != 2'b00) reg_val = d;
                for (int t = 0; t < 200 && cmd_go; t++) @(negedge CLK);
                check("go_fall", 32'(cmd_go), 0);
                repeat ($urandom_range(0, 3)) @(negedge CLK);
                ack_auto = 1'b0;
            end
        end
    end

    // Receiver: returns queued values as valid pulses; data held until the next pulse.
    initial begin : rx_emul
        forever begin
            @(negedge CLK);
            if (resp_q.size() != 0) begin
                rx_busy = 1'b1;
                repeat ($urandom_range(rx_min, rx_max)) @(negedge CLK);
                rx_data  = resp_q.pop_front();
                rx_valid = 1'b1;
                repeat ($urandom_range(3, 5)) @(negedge CLK);
                rx_valid = 1'b0;
                repeat ($urandom_range(3, 5)) @(negedge CLK);
                rx_busy = 1'b0;
            end
        end
    end

    // Per-cycle invariants: legal ctrl, go only while busy, sticky error, stable command fields.
    initial begin : compare
        logic         prev_go = 1'b0;
        logic [W-1:0] held = '0;
        forever begin
            @(negedge CLK);
            if (!RESET && chk_en) begin
                check("ctrl_legal", 32'(cmd_ctrl == 2'b11), 0);
                check("go_implies_busy", 32'(cmd_go && !busy), 0);
                check("busy_done_excl", 32'(busy && done), 0);
                check("error_flag", 32'(error), 32'((err_count != 0) || timeout));
                if (cmd_go && !prev_go) held = {cmd_ctrl, cmd_data};
                else if (cmd_go || cmd_ack) check("cmd_stable", 32'({cmd_ctrl, cmd_data}), 32'(held));
            end
            prev_go = cmd_go;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_rx_idle();
        for (int t = 0; t < 500 && (rx_busy || resp_q.size() != 0); t++) @(negedge CLK);
        check("rx_idle", 32'(rx_busy || resp_q.size() != 0), 0);
        repeat (6) @(negedge CLK);
    endtask

    task automatic run_prep(input int corrupt_nth, input int pct, input bit drop);
        exp_rx = 0; exp_err = 0; rd_no = 0;
        force_corrupt = corrupt_nth; corrupt_pct = pct;
        exp_q.delete();
        model_cmds();
        drop_read = drop ? exp_rx : -1;
    endtask

    task automatic run_finish(input bit drop);
        for (int t = 0; t < 5000 && !done; t++) @(negedge CLK);
        check("run_done", 32'(done), 1);
        wait_rx_idle();
        check("tx_count", 32'(tx_count), NT);
        check("rx_count", 32'(rx_count), exp_rx - int'(drop));
        check("err_count", 32'(err_count), exp_err);
        check("error", 32'(error), 32'(exp_err != 0 || drop));
        check("timeout", 32'(timeout), 32'(drop));
        check("done_busy", 32'({done, busy}), 32'(2'b10));
        check("cmds_left", exp_q.size(), 0);
    endtask

    task automatic do_run(input int corrupt_nth, input int pct, input bit drop);
        run_prep(corrupt_nth, pct, drop);
        pulse_start();
        run_finish(drop);
    endtask

    initial begin : main
        int seen;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_go", 32'(cmd_go), 0);
        check("rst_cmd", 32'({cmd_ctrl, cmd_data}), 0);
        check("rst_counts", 32'(tx_count | rx_count | err_count), 0);
        check("rst_flags", 32'({error, timeout}), 0);
        check("rst_state", 32'(dbg_state), 0);

        // Spurious receive while idle.
        resp_q.push_back(4'hA);
        wait_rx_idle();
        check("spur_rx_count", 32'(rx_count), 1);
        check("spur_err_count", 32'(err_count), 1);
        check("spur_error", 32'(error), 1);
        check("spur_idle", 32'({busy, done}), 0);

        // Ideal run; the directed sequence from INIT 3 reads 3, F, 0, 0 and leaves F.
        run_prep(-1, 0, 1'b0);
`ifndef REG_SEQ_LFSR_EN
        check("pin_model_reads", exp_rx, 4);
`endif
        pulse_start();
        run_finish(1'b0);
`ifndef REG_SEQ_LFSR_EN
        check("pin_rx_count", 32'(rx_count), 4);
        check("pin_err_count", 32'(err_count), 0);
        check("pin_reg_val", 32'(reg_val), 32'h0000000F);
`endif

        do_run(2, 0, 1'b0);
`ifndef REG_SEQ_LFSR_EN
        check("pin_one_mismatch", 32'(err_count), 1);
`endif
        for (int r = 0; r < 4; r++) begin
            rx_min = 3; rx_max = 8 + 10 * r;
            do_run(-1, 25, 1'b0);
        end
        rx_min = 3; rx_max = 8;
        do_run(-1, 0, 1'b1);
        do_run(-1, 0, 1'b0);

        // RESET while go and ack are both high, then start with ack still high.
        chk_en = 1'b0;
        auto_tx = 1'b0;
        ack_man = 1'b0;
        pulse_start();
        for (int t = 0; t < 50 && !cmd_go; t++) @(negedge CLK);
        check("go_before_reset", 32'(cmd_go), 1);
        ack_man = 1'b1;
        RESET = 1'b1;
        @(negedge CLK);
        check("reset_go_low", 32'(cmd_go), 0);
        check("reset_idle", 32'({busy, done}), 0);
        RESET = 1'b0;
        m_idx = 0; m_lfsr = 16'hACE1; reg_val = INIT;
        @(negedge CLK);
        pulse_start();
        seen = 0;
        repeat (12) begin
            if (cmd_go) seen = 1;
            @(negedge CLK);
        end
        check("go_held_while_ack", seen, 0);
        check("busy_waiting", 32'(busy), 1);
        run_prep(-1, 0, 1'b0);
        chk_en = 1'b1;
        auto_tx = 1'b1;
        ack_man = 1'b0;
        run_finish(1'b0);
        do_run(-1, 25, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
